// File: rtl/pipe_tx_sched.sv
// rtl/pipe_tx_sched.sv - PIPE TX lane scheduler: SKP insertion, link commands and packet beats
module pipe_tx_sched #(
    parameter int DATA_W       = 32,
    parameter int SKP_INTERVAL = 354,
    parameter int SKP_PEND_MAX = 3
) (
    input  logic                  phy_pipe_pclk,
    input  logic                  phy_pipe_rst_n,
    input  logic                  tx_enable,
    input  logic                  pkt_valid,
    input  logic [DATA_W-1:0]     pkt_data,
    input  logic [DATA_W/8-1:0]   pkt_k,
    input  logic                  pkt_last,
    output logic                  pkt_ready,
    input  logic                  lcmd_valid,
    input  logic [2*DATA_W-1:0]   lcmd_data,
    output logic                  lcmd_ready,
    output logic [DATA_W-1:0]     pipe_tx_data,
    output logic [DATA_W/8-1:0]   pipe_tx_datak,
    output logic                  pipe_tx_elec_idle,
    output logic                  skp_overflow
);
    localparam int K_W    = DATA_W / 8;
    localparam int CNT_W  = 16;
    localparam int PEND_W = $clog2(SKP_PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(SKP_PEND_MAX);

    typedef enum logic [2:0] {
        ST_EIDLE,
        ST_IDLE,
        ST_PKT,
        ST_LCMD0,
        ST_LCMD1,
        ST_SKP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [K_W-1:0]      datak_q, datak_d;
    logic                eidle_q, eidle_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                skp_sel;
    logic                skp_req;

    // Each cycle picks the beat that goes on the pins next cycle; IDLE, SKP and
    // LCMD1 are the boundary states that choose and emit the first beat of the next unit.
    always_comb begin
        state_d    = state_q;
        data_d     = '0;
        datak_d    = '0;
        eidle_d    = 1'b0;
        pkt_ready  = 1'b0;
        lcmd_ready = 1'b0;
        skp_sel    = 1'b0;
        case (state_q)
            ST_EIDLE: begin
                eidle_d = 1'b1;
                if (tx_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LCMD0: begin
                lcmd_ready = 1'b1;
                data_d     = lcmd_data[2*DATA_W-1:DATA_W];
                state_d    = ST_LCMD1;
            end
            ST_PKT: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    data_d  = pkt_data;
                    datak_d = pkt_k;
                    if (pkt_last) begin
                        state_d = tx_enable ? ST_IDLE : ST_EIDLE;
                    end
                end
            end
            default: begin
                if (!tx_enable) begin
                    eidle_d = 1'b1;
                    state_d = ST_EIDLE;
                end else if (pend_q != '0) begin
                    skp_sel = 1'b1;
                    data_d  = {K_W{8'h3C}};
                    datak_d = '1;
                    state_d = ST_SKP;
                end else if (lcmd_valid) begin
                    data_d  = lcmd_data[DATA_W-1:0];
                    state_d = ST_LCMD0;
                end else if (pkt_valid) begin
                    pkt_ready = 1'b1;
                    data_d    = pkt_data;
                    datak_d   = pkt_k;
                    state_d   = pkt_last ? ST_IDLE : ST_PKT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // SKP interval tracking; counter and pending count freeze in EIDLE.
    always_comb begin
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        skp_req = 1'b0;
        if (state_q != ST_EIDLE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                skp_req = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (skp_req && (pend_q >= PEND_MAX)) begin
            ovf_d = 1'b1;
        end
        if (skp_req && !skp_sel && (pend_q < PEND_MAX)) begin
            pend_d = pend_q + 1'b1;
        end else if (!skp_req && skp_sel) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge phy_pipe_pclk or negedge phy_pipe_rst_n) begin
        if (!phy_pipe_rst_n) begin
            state_q <= ST_EIDLE;
            data_q  <= '0;
            datak_q <= '0;
            eidle_q <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            datak_q <= datak_d;
            eidle_q <= eidle_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pipe_tx_data      = data_q;
    assign pipe_tx_datak     = datak_q;
    assign pipe_tx_elec_idle = eidle_q;
    assign skp_overflow      = ovf_q;

endmodule

// File: tb/tb_pipe_tx_sched.sv
// tb/tb_pipe_tx_sched.sv - directed self-checking bench for pipe_tx_sched
module tb_pipe_tx_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tx_en, pv, pl, lv;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic [63:0] ld;
    logic        pv0, pv1, pv2;
    logic [31:0] od0, od1, od2;
    logic [3:0]  ok0, ok1, ok2;
    logic        oe0, oe1, oe2, or0, or1, or2, olr0, olr1, olr2, ov0, ov1, ov2;
    int          sel;
    logic [31:0] s_d;
    logic [3:0]  s_k;
    logic        s_e, s_r;
    int          checks, errors;
    logic        lcmd_done;
    logic [31:0] cap_d [400];
    logic [3:0]  cap_k [400];
    logic        cap_e [400];
    logic        cap_r [400];
    logic        cap_l [400];

    assign pv0 = pv && (sel == 0);
    assign pv1 = pv && (sel == 1);
    assign pv2 = pv && (sel == 2);

    always_comb begin
        case (sel)
            1:       begin s_d = od1; s_k = ok1; s_e = oe1; s_r = or1; end
            2:       begin s_d = od2; s_k = ok2; s_e = oe2; s_r = or2; end
            default: begin s_d = od0; s_k = ok0; s_e = oe0; s_r = or0; end
        endcase
    end

    pipe_tx_sched u_dut0 (
        .phy_pipe_pclk(clk), .phy_pipe_rst_n(rst_n), .tx_enable(tx_en),
        .pkt_valid(pv0), .pkt_data(pd), .pkt_k(pk), .pkt_last(pl), .pkt_ready(or0),
        .lcmd_valid(lv), .lcmd_data(ld), .lcmd_ready(olr0),
        .pipe_tx_data(od0), .pipe_tx_datak(ok0), .pipe_tx_elec_idle(oe0), .skp_overflow(ov0)
    );
    pipe_tx_sched #(.SKP_INTERVAL(8)) u_dut8 (
        .phy_pipe_pclk(clk), .phy_pipe_rst_n(rst_n), .tx_enable(tx_en),
        .pkt_valid(pv1), .pkt_data(pd), .pkt_k(pk), .pkt_last(pl), .pkt_ready(or1),
        .lcmd_valid(1'b0), .lcmd_data(ld), .lcmd_ready(olr1),
        .pipe_tx_data(od1), .pipe_tx_datak(ok1), .pipe_tx_elec_idle(oe1), .skp_overflow(ov1)
    );
    pipe_tx_sched #(.SKP_INTERVAL(4)) u_dut4 (
        .phy_pipe_pclk(clk), .phy_pipe_rst_n(rst_n), .tx_enable(tx_en),
        .pkt_valid(pv2), .pkt_data(pd), .pkt_k(pk), .pkt_last(pl), .pkt_ready(or2),
        .lcmd_valid(1'b0), .lcmd_data(ld), .lcmd_ready(olr2),
        .pipe_tx_data(od2), .pipe_tx_datak(ok2), .pipe_tx_elec_idle(oe2), .skp_overflow(ov2)
    );

    function automatic logic [31:0] data_of(input int j);
        return 32'hC0DE_0000 + 32'(j);
    endfunction

    function automatic logic [3:0] k_of(input int j);
        return 4'(j);
    endfunction

    task automatic start_lane();
        rst_n = 1'b0; tx_en = 1'b0; pv = 1'b0; lv = 1'b0; pl = 1'b0; lcmd_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tx_en = 1'b1;
        @(posedge clk); #1;
    endtask

    // Cycle 0 is the first cycle in IDLE; cap_* index = cycle number.
    task automatic run_packet(input int n, input int ncyc, input int drop_en_at);
        int beat;
        beat = 0;
        for (int c = 0; c < ncyc; c++) begin
            cap_d[c] = s_d; cap_k[c] = s_k; cap_e[c] = s_e;
            if (c == drop_en_at) tx_en = 1'b0;
            if (beat < n) begin
                pv = 1'b1; pd = data_of(beat); pk = k_of(beat); pl = (beat == n - 1);
            end else begin
                pv = 1'b0; pl = 1'b0;
            end
            #1;
            cap_r[c] = s_r; cap_l[c] = olr0;
            if (pv && s_r) beat++;
            if (lv && olr0) lcmd_done = 1'b1;
            @(posedge clk); #1;
            if (lcmd_done) begin lv = 1'b0; lcmd_done = 1'b0; end
        end
        pv = 1'b0; pl = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; rst_n = 1'b0; tx_en = 1'b0; pv = 1'b0; lv = 1'b0; pl = 1'b0;
        pd = '0; pk = '0; ld = '0; lcmd_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (od0 !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", od0); end
        checks++; if (ok0 !== 4'h0) begin errors++; $display("FAIL reset_datak got %h want 0", ok0); end
        checks++; if (oe0 !== 1'b1) begin errors++; $display("FAIL reset_eidle got %b want 1", oe0); end
        checks++; if ({or0, olr0, olr1, olr2} !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", {or0, olr0, olr1, olr2}); end
        checks++; if ({ov0, ov1, ov2} !== 3'b0) begin errors++; $display("FAIL reset_ovf got %b want 000", {ov0, ov1, ov2}); end
    endtask

    task automatic test_idle_skp();
        int first;
        sel = 0;
        start_lane();
        run_packet(0, 360, -1);
        checks++; if (cap_e[0] !== 1'b1) begin errors++; $display("FAIL en_eidle_c0 got %b want 1", cap_e[0]); end
        checks++; if (cap_e[1] !== 1'b0) begin errors++; $display("FAIL en_eidle_c1 got %b want 0", cap_e[1]); end
        checks++; if ({cap_d[1], cap_k[1]} !== 36'h0) begin errors++; $display("FAIL logical_idle got %h want 0", {cap_d[1], cap_k[1]}); end
        first = -1;
        for (int c = 0; c < 360; c++) begin
            if (first < 0 && cap_d[c] === 32'h3C3C3C3C && cap_k[c] === 4'hF) first = c;
        end
        checks++; if (first - 1 != 354) begin errors++; $display("FAIL first_skp_beat got %0d want 354", first - 1); end
        checks++; if ({cap_d[356], cap_k[356], cap_e[356]} !== 37'h0) begin errors++; $display("FAIL after_skp got %h want 0", {cap_d[356], cap_k[356]}); end
    endtask

    task automatic test_packet();
        sel = 0;
        start_lane();
        run_packet(4, 7, -1);
        for (int c = 0; c < 4; c++) begin
            checks++; if (cap_r[c] !== 1'b1) begin errors++; $display("FAIL pkt_ready c%0d got %b want 1", c, cap_r[c]); end
        end
        checks++; if (cap_r[4] !== 1'b0) begin errors++; $display("FAIL pkt_ready_end got %b want 0", cap_r[4]); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (cap_d[b + 1] !== data_of(b) || cap_k[b + 1] !== k_of(b) || cap_e[b + 1] !== 1'b0) begin
                errors++; $display("FAIL pkt_beat%0d got %h/%h want %h/%h", b, cap_d[b + 1], cap_k[b + 1], data_of(b), k_of(b));
            end
        end
        checks++; if ({cap_d[5], cap_k[5], cap_e[5]} !== 37'h0) begin errors++; $display("FAIL pkt_idle_after got %h want 0", {cap_d[5], cap_k[5]}); end
    endtask

    task automatic test_lcmd_conflict();
        sel = 0;
        start_lane();
        ld = 64'h1111_2222_3333_4444;
        lv = 1'b1;
        run_packet(2, 7, -1);
        checks++; if ({cap_l[0], cap_l[1], cap_l[2]} !== 3'b010) begin errors++; $display("FAIL lcmd_ready got %b want 010", {cap_l[0], cap_l[1], cap_l[2]}); end
        checks++; if ({cap_r[0], cap_r[1], cap_r[2], cap_r[3]} !== 4'b0011) begin errors++; $display("FAIL conflict_pkt_ready got %b want 0011", {cap_r[0], cap_r[1], cap_r[2], cap_r[3]}); end
        checks++; if ({cap_d[1], cap_k[1]} !== {32'h33334444, 4'h0}) begin errors++; $display("FAIL lcmd_lo got %h/%h want 33334444/0", cap_d[1], cap_k[1]); end
        checks++; if ({cap_d[2], cap_k[2]} !== {32'h11112222, 4'h0}) begin errors++; $display("FAIL lcmd_hi got %h/%h want 11112222/0", cap_d[2], cap_k[2]); end
        checks++; if (cap_d[3] !== data_of(0) || cap_d[4] !== data_of(1) || cap_k[4] !== k_of(1)) begin
            errors++; $display("FAIL pkt_after_lcmd got %h %h want %h %h", cap_d[3], cap_d[4], data_of(0), data_of(1));
        end
        checks++; if ({cap_d[5], cap_e[5]} !== 33'h0) begin errors++; $display("FAIL idle_after_lcmd got %h want 0", cap_d[5]); end
    endtask

    task automatic test_skp_burst();
        int bad;
        sel = 1;
        start_lane();
        run_packet(20, 26, -1);
        bad = 0;
        for (int b = 0; b < 20; b++) begin
            if (cap_r[b] !== 1'b1 || cap_d[b + 1] !== data_of(b) || cap_k[b + 1] !== k_of(b)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL skp8_pkt_beats got %0d bad want 0", bad); end
        checks++; if ({cap_d[21], cap_k[21], cap_d[22], cap_k[22]} !== {32'h3C3C3C3C, 4'hF, 32'h3C3C3C3C, 4'hF}) begin
            errors++; $display("FAIL skp8_two_skp got %h %h want 3c3c3c3c x2", cap_d[21], cap_d[22]);
        end
        checks++; if ({cap_d[23], cap_k[23], cap_e[23]} !== 37'h0) begin errors++; $display("FAIL skp8_then_idle got %h/%h want 0", cap_d[23], cap_k[23]); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL skp8_ovf got %b want 0", ov1); end
    endtask

    task automatic test_skp_overflow();
        int bad;
        sel = 2;
        start_lane();
        run_packet(40, 46, -1);
        bad = 0;
        for (int b = 0; b < 40; b++) begin
            if (cap_d[b + 1] !== data_of(b) || cap_k[b + 1] !== k_of(b)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL skp4_pkt_beats got %0d bad want 0", bad); end
        bad = 0;
        for (int c = 41; c < 44; c++) begin
            if (cap_d[c] !== 32'h3C3C3C3C || cap_k[c] !== 4'hF) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL skp4_three_skp got %0d bad want 0", bad); end
        checks++; if ({cap_d[44], cap_k[44]} !== 36'h0) begin errors++; $display("FAIL skp4_fourth got %h/%h want 0", cap_d[44], cap_k[44]); end
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL skp4_ovf got %b want 1", ov2); end
    endtask

    task automatic test_eidle_reset();
        logic got;
        sel = 0;
        start_lane();
        run_packet(4, 6, 1);
        checks++; if ({cap_r[0], cap_r[1], cap_r[2], cap_r[3]} !== 4'b1111) begin errors++; $display("FAIL drop_en_ready got %b want 1111", {cap_r[0], cap_r[1], cap_r[2], cap_r[3]}); end
        checks++; if (cap_d[4] !== data_of(3) || cap_e[4] !== 1'b0) begin errors++; $display("FAIL drop_en_last got %h want %h", cap_d[4], data_of(3)); end
        checks++; if ({cap_e[5], cap_d[5]} !== {1'b1, 32'h0}) begin errors++; $display("FAIL drop_en_eidle got %b/%h want 1/0", cap_e[5], cap_d[5]); end
        tx_en = 1'b1;
        ld = 64'hDEAD_BEEF_0BAD_F00D;
        lv = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (olr0) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL lcmd_wait got timeout want lcmd_ready"); end
        checks++; if (od0 !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_lcmd_data got %h want 0badf00d", od0); end
        rst_n = 1'b0;
        #1;
        checks++; if ({od0, ok0, oe0} !== {32'h0, 4'h0, 1'b1}) begin errors++; $display("FAIL async_rst_pins got %h/%h/%b want 0/0/1", od0, ok0, oe0); end
        checks++; if ({olr0, or0, ov0} !== 3'b0) begin errors++; $display("FAIL async_rst_ctrl got %b want 000", {olr0, or0, ov0}); end
        lv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle_skp();
        test_packet();
        test_lcmd_conflict();
        test_skp_burst();
        test_skp_overflow();
        test_eidle_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_tx_sched.md
Name: pipe_tx_sched

Overview:
Schedules the single PIPE transmit lane toward the PHY. Three sources share the lane: periodic SKP ordered-set insertion, link commands (LCMD) and link-layer packet beats. The block inserts SKPs only at packet boundaries and drives logical idle or electrical idle when nothing is pending. It sits between the link layer and the PHY PIPE interface and runs entirely in the PIPE pclk domain.

Parameters:
DATA_W, 32, PIPE TxData width (4 symbols/beat); TxDataK width is DATA_W/8
SKP_INTERVAL, 354, output beats between SKP insertion requests (1..65535)
SKP_PEND_MAX, 3, saturation value of the pending-SKP counter

Ports:
phy_pipe_pclk  in  1  PIPE clock; all logic rising-edge
phy_pipe_rst_n  in  1  async active-low reset
tx_enable  in  1  1 = lane active; 0 = electrical idle after current unit
pkt_valid  in  1  packet beat valid
pkt_data  in  DATA_W  packet beat data
pkt_k  in  DATA_W/8  per-symbol K flags
pkt_last  in  1  final beat of packet
pkt_ready  out  1  beat accepted when pkt_valid&pkt_ready
lcmd_valid  in  1  link command request (held until accepted)
lcmd_data  in  2*DATA_W  8-symbol LCMD; low word sent first
lcmd_ready  out  1  one-cycle accept pulse
pipe_tx_data  out  DATA_W  TxData
pipe_tx_datak  out  DATA_W/8  TxDataK
pipe_tx_elec_idle  out  1  TxElecIdle
skp_overflow  out  1  sticky: SKP request arrived while pending count saturated

Behaviour:
- Reset state (async, phy_pipe_rst_n=0): state=EIDLE. pipe_tx_data=0, pipe_tx_datak=0, pipe_tx_elec_idle=1, pkt_ready=0, lcmd_ready=0, skp_overflow=0. Beat counter and pending count are 0.
- All PIPE outputs are registered. A decision made in cycle N appears on the pins in cycle N+1.
- States: EIDLE, IDLE, PKT, LCMD0, LCMD1, SKP.
- A boundary cycle is any cycle in state IDLE, SKP, or LCMD1. In PKT, the cycle that accepts pkt_last is also a boundary. At a boundary the next unit is chosen by fixed priority:
  1. SKP if pending>0.
  2. LCMD0 if lcmd_valid.
  3. PKT if pkt_valid.
  4. Otherwise IDLE.
- EIDLE: outputs elec_idle=1, data=0, datak=0. Moves to IDLE when tx_enable=1. Exits from any boundary to EIDLE when tx_enable=0; tx_enable is ignored mid-packet and mid-LCMD.
- IDLE: elec_idle=0, data=0, datak=0 (logical idle).
- SKP: one beat, data={4{8'h3C}} (K28.1), datak=all ones, pending decrements by 1.
- LCMD0: outputs lcmd_data[DATA_W-1:0] with datak=0; lcmd_ready pulses in this cycle.
- LCMD1: outputs the upper word with datak=0.
- PKT:
  - pkt_ready=1 combinationally whenever state=PKT, or when a boundary selects PKT.
  - Each accepted beat is forwarded unchanged to data/datak.
  - pkt_valid=0 mid-packet: emit logical idle and stay in PKT. SKP is never inserted mid-packet.
- Beat counter: increments every cycle the state is not EIDLE. On reaching SKP_INTERVAL-1 it wraps to 0 and raises a SKP request.
  - If pending<SKP_PEND_MAX, pending increments.
  - Otherwise skp_overflow sets. It is sticky and cleared only by reset.
  - A request and an SKP beat in the same cycle leave pending unchanged.
- Counter and pending are held (not cleared) in EIDLE.
- LCMD and a packet start in the same cycle: LCMD wins; the packet waits with pkt_ready=0.

Test Plan:
- Reset, then tx_enable=1 with no traffic -> elec_idle drops 2 cycles after enable; data=0, datak=0. First SKP beat 0x3C3C3C3C/K=0xF appears at beat 354.
- 4-beat packet with pkt_valid held -> pkt_ready high 4 cycles; the beats appear on pipe_tx_data one cycle later in order, datak mirrored.
- lcmd_valid, lcmd_data=64'h1111_2222_3333_4444 -> one lcmd_ready pulse; pins show 0x33334444 then 0x11112222, datak=0.
- SKP_INTERVAL=8, continuous 20-beat packet -> no SKP mid-packet; pending=2 at pkt_last; two SKP beats follow immediately, then the next unit.
- SKP_INTERVAL=4, 40-beat packet -> pending saturates at 3 and skp_overflow=1; exactly 3 SKP beats follow the packet.
- tx_enable dropped mid-packet, then phy_pipe_rst_n asserted mid-LCMD -> packet completes, then elec_idle=1. Reset forces all outputs to reset values immediately, without waiting for a clock.
